// File: rtl/product_accumulator.sv
// Frame accumulator for multiplier products: sums up to LEN unsigned products per frame
// with saturation, and presents one result per frame on a valid/ready output port.
module product_accumulator #(
    parameter int IN_W  = 6,
    parameter int ACC_W = 8,
    parameter int LEN   = 8,
    parameter int CNT_W = $clog2(LEN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_product,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_sat
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);

    state_t             state_reg, state_next;
    logic [ACC_W-1:0]   acc_reg, acc_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               sat_reg, sat_next;
    logic               out_valid_reg, out_valid_next;
    logic [ACC_W-1:0]   out_sum_reg, out_sum_next;
    logic [CNT_W-1:0]   out_count_reg, out_count_next;
    logic               out_sat_reg, out_sat_next;

    logic               accept;
    logic               frame_end;
    logic               overflow;
    logic [ACC_W:0]     sum_wide;
    logic [ACC_W-1:0]   sum_sat;

    // One extra bit catches the carry so the saturated value never shows a wrap.
    assign sum_wide  = {1'b0, acc_reg} + {{(ACC_W + 1 - IN_W){1'b0}}, in_product};
    assign overflow  = sum_wide[ACC_W];
    assign sum_sat   = overflow ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
    assign frame_end = (cnt_reg == CNT_LAST) || in_last;

    assign in_ready = !clear && ((state_reg == ACCUM) || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_next     = state_reg;
        acc_next       = acc_reg;
        cnt_next       = cnt_reg;
        sat_next       = sat_reg;
        out_valid_next = out_valid_reg;
        out_sum_next   = out_sum_reg;
        out_count_next = out_count_reg;
        out_sat_next   = out_sat_reg;

        if (clear) begin
            state_next     = ACCUM;
            acc_next       = '0;
            cnt_next       = '0;
            sat_next       = 1'b0;
            out_valid_next = 1'b0;
        end else begin
            // acc/cnt/sat are already zero in HOLD, so an accepted product there
            // naturally becomes the first sample of the next frame.
            if (state_reg == HOLD && out_ready) begin
                state_next     = ACCUM;
                out_valid_next = 1'b0;
            end
            if (accept) begin
                if (frame_end) begin
                    out_sum_next   = sum_sat;
                    out_count_next = cnt_reg + CNT_ONE;
                    out_sat_next   = sat_reg | overflow;
                    out_valid_next = 1'b1;
                    acc_next       = '0;
                    cnt_next       = '0;
                    sat_next       = 1'b0;
                    state_next     = HOLD;
                end else begin
                    acc_next = sum_sat;
                    cnt_next = cnt_reg + CNT_ONE;
                    sat_next = sat_reg | overflow;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ACCUM;
            acc_reg       <= '0;
            cnt_reg       <= '0;
            sat_reg       <= 1'b0;
            out_valid_reg <= 1'b0;
            out_sum_reg   <= '0;
            out_count_reg <= '0;
            out_sat_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            acc_reg       <= acc_next;
            cnt_reg       <= cnt_next;
            sat_reg       <= sat_next;
            out_valid_reg <= out_valid_next;
            out_sum_reg   <= out_sum_next;
            out_count_reg <= out_count_next;
            out_sat_reg   <= out_sat_next;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_sum   = out_sum_reg;
    assign out_count = out_count_reg;
    assign out_sat   = out_sat_reg;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed-vector bench for product_accumulator: each task drives one scenario and
// checks outputs one time unit after the active clock edge.
module tb_product_accumulator;

    localparam int IN_W  = 6;
    localparam int ACC_W = 8;
    localparam int LEN   = 8;
    localparam int CNT_W = $clog2(LEN + 1);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clear = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [IN_W-1:0]  in_product = '0;
    logic             in_last = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [ACC_W-1:0] out_sum;
    logic [CNT_W-1:0] out_count;
    logic             out_sat;

    int tests = 0;
    int fails = 0;

    product_accumulator #(.IN_W(IN_W), .ACC_W(ACC_W), .LEN(LEN)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_product(in_product), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_count(out_count), .out_sat(out_sat)
    );

    always #5 clk = ~clk;

    // Present one product for exactly one edge; caller ensures in_ready is high.
    task automatic drive(input logic [IN_W-1:0] p, input logic last);
        in_valid   = 1'b1;
        in_product = p;
        in_last    = last;
        @(posedge clk); #1;
        in_valid   = 1'b0;
        in_last    = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; in_product = 6'd5;
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
        tests++; if (out_sum !== 8'd0) begin fails++; $display("FAIL reset_sum: got %0d want 0", out_sum); end
        tests++; if (out_count !== 4'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", out_count); end
        tests++; if (out_sat !== 1'b0) begin fails++; $display("FAIL reset_sat: got %0b want 0", out_sat); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
        $display("[TB] reset done");
    endtask

    task automatic test_full_frame();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) drive(6'd6, 1'b0);
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL full_valid: got %0b want 1", out_valid); end
        tests++; if (out_sum !== 8'd48) begin fails++; $display("FAIL full_sum: got %0d want 48", out_sum); end
        tests++; if (out_count !== 4'd8) begin fails++; $display("FAIL full_count: got %0d want 8", out_count); end
        tests++; if (out_sat !== 1'b0) begin fails++; $display("FAIL full_sat: got %0b want 0", out_sat); end
        @(posedge clk); #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL full_valid_drop: got %0b want 0", out_valid); end
        $display("[TB] full frame 8x6 sum=%0d count=%0d", out_sum, out_count);
    endtask

    task automatic test_saturation();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) drive(6'd49, 1'b0);
        tests++; if (out_sum !== 8'd255) begin fails++; $display("FAIL sat_sum: got %0d want 255", out_sum); end
        tests++; if (out_count !== 4'd8) begin fails++; $display("FAIL sat_count: got %0d want 8", out_count); end
        tests++; if (out_sat !== 1'b1) begin fails++; $display("FAIL sat_flag: got %0b want 1", out_sat); end
        // Next frame follows back-to-back and must start with a clean sat flag.
        for (int i = 0; i < 8; i++) begin
            drive(6'd1, 1'b0);
            if (i == 0) begin
                tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_consumed: got %0b want 0", out_valid); end
            end
        end
        tests++; if (out_sum !== 8'd8) begin fails++; $display("FAIL sat_next_sum: got %0d want 8", out_sum); end
        tests++; if (out_sat !== 1'b0) begin fails++; $display("FAIL sat_next_flag: got %0b want 0", out_sat); end
        $display("[TB] saturation frame then 8x1 sum=%0d sat=%0b", out_sum, out_sat);
    endtask

    task automatic test_short_frames();
        out_ready = 1'b1;
        drive(6'd5, 1'b0); drive(6'd10, 1'b0); drive(6'd20, 1'b1);
        tests++; if (out_sum !== 8'd35) begin fails++; $display("FAIL short_sum: got %0d want 35", out_sum); end
        tests++; if (out_count !== 4'd3) begin fails++; $display("FAIL short_count: got %0d want 3", out_count); end
        for (int i = 0; i < 4; i++) drive(6'd1, i == 3);
        tests++; if (out_sum !== 8'd4) begin fails++; $display("FAIL short4_sum: got %0d want 4", out_sum); end
        tests++; if (out_count !== 4'd4) begin fails++; $display("FAIL short4_count: got %0d want 4", out_count); end
        @(posedge clk); #1;
        // in_last on the LEN-th product ends the frame exactly once.
        for (int i = 0; i < 8; i++) drive(6'd63, i == 7);
        tests++; if (out_count !== 4'd8) begin fails++; $display("FAIL last_len_count: got %0d want 8", out_count); end
        tests++; if (out_sum !== 8'd255) begin fails++; $display("FAIL last_len_sum: got %0d want 255", out_sum); end
        @(posedge clk); #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL last_len_once: got %0b want 0", out_valid); end
        $display("[TB] short frames done");
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) drive(6'd2, 1'b0);
        in_valid = 1'b1; in_product = 6'd9;
        for (int i = 0; i < 5; i++) begin
            #1;
            tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready[%0d]: got %0b want 0", i, in_ready); end
            tests++; if (out_valid !== 1'b1 || out_sum !== 8'd16) begin
                fails++; $display("FAIL bp_hold[%0d]: got valid=%0b sum=%0d want valid=1 sum=16", i, out_valid, out_sum);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_release_ready: got %0b want 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_consumed: got %0b want 0", out_valid); end
        for (int i = 0; i < 7; i++) drive(6'd1, 1'b0);
        tests++; if (out_sum !== 8'd16 || out_count !== 4'd8) begin
            fails++; $display("FAIL bp_next_frame: got sum=%0d count=%0d want sum=16 count=8", out_sum, out_count);
        end
        @(posedge clk); #1;
        $display("[TB] backpressure done sum=%0d", out_sum);
    endtask

    task automatic test_clear();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) drive(6'd10, 1'b0);
        clear = 1'b1; in_valid = 1'b1; in_product = 6'd7;
        #1;
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL clear_in_ready: got %0b want 0", in_ready); end
        @(posedge clk); #1;
        clear = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 8; i++) drive(6'd3, 1'b0);
        tests++; if (out_sum !== 8'd24 || out_count !== 4'd8) begin
            fails++; $display("FAIL clear_frame: got sum=%0d count=%0d want sum=24 count=8", out_sum, out_count);
        end
        // clear while a result is held drops out_valid on the next edge.
        out_ready = 1'b0;
        drive(6'd4, 1'b1);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL clear_hold: got %0b want 0", out_valid); end
        // Asynchronous reset while holding.
        drive(6'd4, 1'b1);
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL rst_pre_hold: got %0b want 1", out_valid); end
        rst_n = 1'b0;
        #1;
        tests++; if (out_valid !== 1'b0 || out_sum !== 8'd0) begin
            fails++; $display("FAIL rst_async: got valid=%0b sum=%0d want valid=0 sum=0", out_valid, out_sum);
        end
        @(posedge clk); #1;
        rst_n = 1'b1; out_ready = 1'b1;
        drive(6'd12, 1'b1);
        tests++; if (out_sum !== 8'd12 || out_count !== 4'd1) begin
            fails++; $display("FAIL rst_recover: got sum=%0d count=%0d want sum=12 count=1", out_sum, out_count);
        end
        $display("[TB] clear and reset done");
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_saturation();
        test_short_frames();
        test_backpressure();
        test_clear();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
